// File: rtl/md_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide sequencer.
package md_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing a HI/LO pair.
module md_arith
  import md_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_result_t        res_c
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   quo_mag;
  logic [DATA_W-1:0]   rem_mag;
  logic [DATA_W-1:0]   quo_s;
  logic [DATA_W-1:0]   rem_s;
  logic [DATA_W-1:0]   quo_u;
  logic [DATA_W-1:0]   rem_u;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Signed divide on magnitudes; INT_MIN / -1 wraps back to INT_MIN with rem 0.
  assign a_neg   = a[DATA_W-1];
  assign b_neg   = b[DATA_W-1];
  assign a_mag   = a_neg ? (~a + DATA_W'(1)) : a;
  assign b_mag   = b_neg ? (~b + DATA_W'(1)) : b;
  assign quo_mag = a_mag / b_mag;
  assign rem_mag = a_mag % b_mag;
  assign quo_s   = (a_neg ^ b_neg) ? (~quo_mag + DATA_W'(1)) : quo_mag;
  assign rem_s   = a_neg ? (~rem_mag + DATA_W'(1)) : rem_mag;
  assign quo_u   = a / b;
  assign rem_u   = a % b;

  // Result select; divide by zero yields all-ones quotient and the dividend as remainder.
  always_comb begin
    res_c = '0;
    unique case (md_op_e'(op))
      MD_MULT:  res_c = md_result_t'(prod_s);
      MD_MULTU: res_c = md_result_t'(prod_u);
      MD_DIV: begin
        if (b == '0) begin
          res_c.hi = a;
          res_c.lo = '1;
        end else begin
          res_c.hi = rem_s;
          res_c.lo = quo_s;
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          res_c.hi = a;
          res_c.lo = '1;
        end else begin
          res_c.hi = rem_u;
          res_c.lo = quo_u;
        end
      end
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multi-cycle multiply/divide controller for the EX stage.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              if_mthi,
  input  logic              if_mtlo,
  input  logic              cancel,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e        state;
  logic [CNT_W-1:0] count;
  md_result_t       pend;
  md_result_t       arith_res;

  md_arith u_arith (
    .op    (op),
    .a     (rs_val),
    .b     (rt_val),
    .res_c (arith_res)
  );

  // FSM: capture result at issue, count down the latency, commit to HI/LO on the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cancel) begin
            if (start) begin
              pend  <= arith_res;
              count <= op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              if (if_mthi) hi <= rs_val;
              if (if_mtlo) lo <= rs_val;
            end
          end
        end
        RUN: begin
          if (count == CNT_W'(1)) begin
            hi    <= pend.hi;
            lo    <= pend.lo;
            busy  <= 1'b0;
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus random traffic against a cycle model.
module tb_md_sequencer;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        if_mthi;
  logic        if_mtlo;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: architectural HI/LO, pending result and busy cycles left.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .if_mthi (if_mthi),
    .if_mtlo (if_mtlo),
    .cancel  (cancel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi, lo} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] u;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      2'b01: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hi   = '0;
    m_lo   = '0;
    m_pend = '0;
    m_left = 0;
  endtask

  task automatic model_step(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic mh, input logic ml, input logic c);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (!c) begin
      if (s) begin
        m_pend = ref_md(o, a, b);
        m_left = o[1] ? DIV_LAT : MULT_LAT;
      end else begin
        if (mh) m_hi = a;
        if (ml) m_lo = a;
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, sample 1 time unit later.
  task automatic cyc(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic mh, input logic ml, input logic c);
    @(negedge clk);
    start   = s;
    op      = o;
    rs_val  = a;
    rt_val  = b;
    if_mthi = mh;
    if_mtlo = ml;
    cancel  = c;
    @(posedge clk);
    model_step(s, o, a, b, mh, ml, c);
    #1;
    check("busy", 32'(busy), 32'(m_left != 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Issue an op and run until busy drops; n is the number of cycles busy was seen high.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
    cyc(1'b1, o, a, b, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      idle();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs_val  = '0;
    rt_val  = '0;
    if_mthi = 1'b0;
    if_mtlo = 1'b0;
    cancel  = 1'b0;
    model_reset();
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();

    // mult / multu of -1 and 2
    issue(2'b00, 32'hFFFF_FFFF, 32'd2, n);
    check("mult_lat", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, n);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // Divide cases including the special ones
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    check("div_lat", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(2'b11, 32'd7, 32'd0, n);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // Moves, then start with cancel must do nothing
    cyc(1'b0, 2'b00, 32'h11, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 32'h22, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    check("cancel_busy", 32'(busy), 32'd0);
    idle();
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);

    // mtlo while idle
    cyc(1'b0, 2'b00, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0);
    check("mtlo_lo", lo, 32'hDEAD_BEEF);
    check("mtlo_hi", hi, 32'h11);

    // mthi during RUN is ignored
    cyc(1'b1, 2'b00, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 32'h55, 32'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      idle();
    end
    check("run_mthi_hi", hi, 32'd3);
    check("run_mthi_lo", lo, 32'd0);

    // Reset in cycle 3 of a div aborts it
    cyc(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) idle();
    check("norcommit_lo", lo, 32'd0);
    issue(2'b00, 32'd6, 32'd7, n);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    // Back-to-back: new start in the first cycle busy is low
    issue(2'b00, 32'd3, 32'd5, n);
    check("b2b_first_lo", lo, 32'd15);
    issue(2'b01, 32'h100, 32'h100, n);
    check("b2b_lat", 32'(n), 32'd5);
    check("b2b_second_lo", lo, 32'h0001_0000);
    check("b2b_second_hi", hi, 32'd0);

    // Random traffic; start is only offered while the model is idle
    for (int k = 0; k < 400; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (m_left == 0) begin
        if (r < 5)
          cyc(1'b1, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0, 1'b0,
              ($urandom_range(0, 7) == 0));
        else if (r < 8)
          cyc(1'b0, 2'b00, 32'($urandom), 32'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0));
        else
          idle();
      end else begin
        cyc(1'b0, 2'b00, 32'($urandom), 32'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Multi-cycle controller for the HI/LO multiply/divide resource in the EX stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu issue and mthi/mtlo writes from the EX-stage controller.
- Holds the operation in flight for a fixed latency, then commits the result to the HI/LO architectural registers.
- Produces the busy indication the hazard unit uses to stall mfhi/mflo/md instructions.
- Honours a cancel input so that an instruction flushed by an interrupt never starts.

Parameters:
MULT_LAT, 5, cycles busy stays high for mult/multu (must be ≥1).
DIV_LAT, 10, cycles busy stays high for div/divu (must be ≥1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  issue pulse for a mult/div in EX.
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
rs_val  input  32  forwarded rs operand (dividend/multiplicand).
rt_val  input  32  forwarded rt operand (divisor/multiplier).
if_mthi  input  1  write rs_val to HI.
if_mtlo  input  1  write rs_val to LO.
cancel  input  1  interrupt flush of the EX instruction; suppresses start/mthi/mtlo this cycle.
busy  output  1  operation in flight.
hi  output  32  architectural HI.
lo  output  32  architectural LO.

Behaviour:
Reset:
- Async assert sets state=IDLE, count=0, busy=0, hi=0, lo=0, pending regs=0.
- Reset mid-operation aborts the operation; HI/LO stay 0 and no commit ever occurs.

States:
- IDLE, RUN.
- IDLE→RUN on accepted start. RUN→IDLE when count reaches 1, and that same edge commits.

Accept rules:
- start is accepted only when state=IDLE and cancel=0.
- start during RUN is ignored. The hazard unit guarantees it never happens; the verifier asserts it.

Issue cycle (edge at end of the start cycle):
- Compute {pend_hi, pend_lo} from rs_val/rt_val combinationally and register them.
- Load count = MULT_LAT or DIV_LAT. Set busy=1.
- busy is registered: it is low in the start cycle itself. The hazard unit uses start|busy.

RUN:
- Decrement count each edge.
- At the edge where count==1: hi<=pend_hi, lo<=pend_lo, busy<=0, state<=IDLE.
- Total: busy high for exactly LAT cycles. New HI/LO are visible on the first cycle busy is low.

Arithmetic:
- mult: signed 32x32→64, hi=[63:32], lo=[31:0].
- multu: unsigned 32x32→64, same split.
- div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero: lo=32'hFFFFFFFF, hi=dividend. No exception.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.

mthi/mtlo:
- Take effect at the edge of the asserting cycle only when state=IDLE and cancel=0.
- mthi and mtlo in the same cycle write both.
- mthi/mtlo asserted together with start: start wins; the move is dropped (illegal, asserted against).
- mthi/mtlo while RUN are ignored.
- The RUN commit always overwrites both HI and LO.

Simultaneous start and cancel: nothing happens; state, busy, hi and lo are unchanged.

Decomposition:
- Package md_pkg holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state enum {IDLE, RUN};
  - latency defaults.
- One combinational sub-module, md_arith (op, a, b → hi64/lo), isolates the signed/unsigned multiply/divide and its special cases.
- The sequencer keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- mult, rs=0xFFFFFFFF, rt=2 → busy high cycles 1..5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (−7), rt=2 → busy exactly 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 → lo=0xFFFFFFFF, hi=7. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- start=1 with cancel=1 (op=mult, 3×4) → busy stays 0; hi/lo keep their prior values, e.g. 0x11/0x22 after mthi/mtlo.
- mtlo rs=0xDEADBEEF while idle → lo=0xDEADBEEF next cycle. mthi during RUN of a mult → ignored; final hi equals the mult result.
- reset pulse at cycle 3 of a div → busy=0, hi=lo=0 immediately; no commit afterwards; a new mult 6×7 then yields lo=42, hi=0.
- Back-to-back: a start in the first cycle busy falls after a mult → new op accepted; the previous result is visible in that cycle; the second result commits after its own latency.
